// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined multi-lane barrel shifter.
package shifter_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int LVL       = $clog2(DEF_WIDTH);
    localparam int MAX_W     = 64;

    typedef enum logic [2:0] {
        OP_LSR = 3'd0,
        OP_LSL = 3'd1,
        OP_ASR = 3'd2,
        OP_ROR = 3'd3,
        OP_ROL = 3'd4
    } shift_op_e;

    // Sum keeps its carry so an overflowing pair still counts as a huge shift.
    function automatic logic [MAX_W:0] eff_amt(input logic [MAX_W-1:0] amt,
                                               input logic [MAX_W-1:0] amt2,
                                               input logic             sum);
        eff_amt = sum ? ({1'b0, amt} + {1'b0, amt2}) : {1'b0, amt};
    endfunction

endpackage

// File: rtl/shifter_lane_stage.sv
// One pipeline rank of one lane: applies shifter levels [LO,HI) and registers the result.
module shifter_lane_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = LVL,
    parameter int LO    = 0,
    parameter int HI    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_advance,
    input  logic [WIDTH:0]   i_ext,
    input  logic [AW-1:0]    i_amt,
    input  logic             i_fill,
    input  logic             i_rot,
    input  logic             i_left,
    output logic [WIDTH:0]   o_ext,
    output logic [AW-1:0]    o_amt,
    output logic             o_fill,
    output logic             o_rot,
    output logic             o_left
);

    logic [WIDTH:0] w_ext;

    // Data lives in [WIDTH:1]; bit 0 catches the last bit shifted out (the carry candidate).
    always_comb begin
        w_ext = i_ext;
        for (int lv = LO; lv < HI; lv++) begin
            if (i_amt[lv]) begin
                if (i_rot) begin
                    w_ext = {(w_ext[WIDTH:1] >> (1 << lv)) | (w_ext[WIDTH:1] << (WIDTH - (1 << lv))),
                             w_ext[0]};
                end else begin
                    w_ext = (w_ext >> (1 << lv)) |
                            ({(WIDTH+1){i_fill}} & ~({(WIDTH+1){1'b1}} >> (1 << lv)));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_ext  <= '0;
            o_amt  <= '0;
            o_fill <= 1'b0;
            o_rot  <= 1'b0;
            o_left <= 1'b0;
        end else if (i_advance) begin
            o_ext  <= w_ext;
            o_amt  <= i_amt;
            o_fill <= i_fill;
            o_rot  <= i_rot;
            o_left <= i_left;
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined multi-lane barrel shifter with valid/ready on both sides.
// Left ops run as right ops on bit-reversed data so every rank only shifts right.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LANES  = 2,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic                     in_sum,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic [LANES*WIDTH-1:0]   in_amt,
    input  logic [WIDTH-1:0]         in_amt2,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [LANES-1:0]         out_carry,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int AW  = $clog2(WIDTH);
    localparam int PER = AW / STAGES;

    logic [WIDTH:0]    w_inExt  [LANES];
    logic [AW-1:0]     w_inAmt  [LANES];
    logic              w_inFill [LANES];
    logic              w_inRot  [LANES];
    logic              w_inLeft [LANES];

    logic [WIDTH:0]    w_stExt  [STAGES][LANES];
    logic [AW-1:0]     w_stAmt  [STAGES][LANES];
    logic              w_stFill [STAGES][LANES];
    logic              w_stRot  [STAGES][LANES];
    logic              w_stLeft [STAGES][LANES];

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_adv;
    logic [TAG_W-1:0]  r_tag [STAGES];

    function automatic logic [WIDTH-1:0] reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int b = 0; b < WIDTH; b++) begin
            r[b] = v[WIDTH-1-b];
        end
        return r;
    endfunction

    // Oversized shifts are resolved here by preloading the final value with a zero amount.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            logic [WIDTH-1:0] x;
            logic [WIDTH-1:0] d;
            logic [WIDTH:0]   ea;
            logic             big;
            logic             exact;
            logic             left;
            x     = in_data[l*WIDTH +: WIDTH];
            ea    = (WIDTH+1)'(eff_amt(MAX_W'(in_amt[l*WIDTH +: WIDTH]), MAX_W'(in_amt2),
                                       in_sum && (l == 0)));
            left  = (in_op == OP_LSL) || (in_op == OP_ROL);
            d     = left ? reverse(x) : x;
            big   = |ea[WIDTH:AW];
            exact = (ea == (WIDTH+1)'(WIDTH));

            w_inExt[l]  = {d, 1'b0};
            w_inAmt[l]  = ea[AW-1:0];
            w_inFill[l] = 1'b0;
            w_inRot[l]  = 1'b0;
            w_inLeft[l] = left;
            case (in_op)
                OP_LSR, OP_LSL: begin
                    if (big) begin
                        w_inExt[l] = {{WIDTH{1'b0}}, exact & d[WIDTH-1]};
                        w_inAmt[l] = '0;
                    end
                end
                OP_ASR: begin
                    w_inFill[l] = x[WIDTH-1];
                    if (big) begin
                        w_inExt[l] = {(WIDTH+1){x[WIDTH-1]}};
                        w_inAmt[l] = '0;
                    end
                end
                OP_ROR, OP_ROL: begin
                    w_inRot[l] = 1'b1;
                end
                default: begin
                    w_inExt[l]  = {x, 1'b0};
                    w_inAmt[l]  = '0;
                    w_inLeft[l] = 1'b0;
                end
            endcase
            if (in_sum && (l != 0)) begin
                w_inExt[l]  = '0;
                w_inAmt[l]  = '0;
                w_inFill[l] = 1'b0;
                w_inRot[l]  = 1'b0;
                w_inLeft[l] = 1'b0;
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_rank
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [WIDTH:0] w_srcExt;
            logic [AW-1:0]  w_srcAmt;
            logic           w_srcFill;
            logic           w_srcRot;
            logic           w_srcLeft;

            if (k == 0) begin : g_first
                assign w_srcExt  = w_inExt[l];
                assign w_srcAmt  = w_inAmt[l];
                assign w_srcFill = w_inFill[l];
                assign w_srcRot  = w_inRot[l];
                assign w_srcLeft = w_inLeft[l];
            end else begin : g_next
                assign w_srcExt  = w_stExt[k-1][l];
                assign w_srcAmt  = w_stAmt[k-1][l];
                assign w_srcFill = w_stFill[k-1][l];
                assign w_srcRot  = w_stRot[k-1][l];
                assign w_srcLeft = w_stLeft[k-1][l];
            end

            shifter_lane_stage #(
                .WIDTH (WIDTH),
                .AW    (AW),
                .LO    (k * PER),
                .HI    ((k == STAGES - 1) ? AW : (k + 1) * PER)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .i_advance (w_adv[k]),
                .i_ext     (w_srcExt),
                .i_amt     (w_srcAmt),
                .i_fill    (w_srcFill),
                .i_rot     (w_srcRot),
                .i_left    (w_srcLeft),
                .o_ext     (w_stExt[k][l]),
                .o_amt     (w_stAmt[k][l]),
                .o_fill    (w_stFill[k][l]),
                .o_rot     (w_stRot[k][l]),
                .o_left    (w_stLeft[k][l])
            );
        end
    end

    // A rank moves when it is empty or its successor moves, so bubbles collapse.
    always_comb begin
        logic nextAdv;
        nextAdv = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_adv[k] = !r_valid[k] || nextAdv;
            nextAdv  = w_adv[k];
        end
    end

    assign in_ready = w_adv[0] && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= in_valid;
                r_tag[0]   <= in_tag;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    r_tag[k]   <= r_tag[k-1];
                end
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];

    // Rotate carry is the result MSB in the (possibly reversed) right-rotate domain.
    always_comb begin
        out_data  = '0;
        out_carry = '0;
        for (int l = 0; l < LANES; l++) begin
            logic [WIDTH-1:0] y;
            y = w_stExt[STAGES-1][l][WIDTH:1];
            out_carry[l] = w_stRot[STAGES-1][l] ? ((|w_stAmt[STAGES-1][l]) & y[WIDTH-1])
                                                : w_stExt[STAGES-1][l][0];
            out_data[l*WIDTH +: WIDTH] = w_stLeft[STAGES-1][l] ? reverse(y) : y;
        end
    end

endmodule
